// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding and default width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_mul(input logic [2:0] opcode);
        return opcode == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_cells.sv
// Combinational ALU part cells: adder, bitwise logic cells and magnitude comparator.
module full_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module ander #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = a[gi] & b[gi];
    end
endmodule

module orer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = a[gi] | b[gi];
    end
endmodule

module xorer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = a[gi] ^ b[gi];
    end
endmodule

module notter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = ~a[gi];
    end
endmodule

module comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             a_larger,
    output logic             equal
);
    // c is the bitwise difference pattern; all-zero exactly when the operands match
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign c[gi] = a[gi] ^ b[gi];
    end
    assign a_larger = a > b;
    assign equal    = a == b;
endmodule

// File: rtl/shift_add_mul_core.sv
// Iterative unsigned shift-and-add multiplier, one iteration per step, WIDTH steps per product.
module shift_add_mul_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               last,
    output logic [2*WIDTH-1:0] product_next
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] hi_next;
    logic             c_next;

    full_adder #(.WIDTH(WIDTH)) u_full_adder (
        .a   (hi_reg),
        .b   (mcand_reg),
        .cin (1'b0),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // Conditional add of the multiplicand, then the whole {c,hi,lo} shifts right by one
    always_comb begin
        hi_next      = lo_reg[0] ? fa_sum : hi_reg;
        c_next       = lo_reg[0] & fa_cout;
        product_next = {c_next, hi_next, lo_reg[WIDTH-1:1]};
    end

    assign last = step && (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            count_reg <= '0;
        end else if (load) begin
            mcand_reg <= multiplicand;
            hi_reg    <= '0;
            lo_reg    <= multiplier;
            count_reg <= '0;
        end else if (step) begin
            hi_reg    <= product_next[2*WIDTH-1:WIDTH];
            lo_reg    <= product_next[WIDTH-1:0];
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU stage: start/busy/done handshake, single-cycle logic/arith ops and
// a WIDTH-cycle shift-and-add multiply; result and flags are registered and held.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               a_larger,
    output logic               equal,
    output logic               err
);
    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               a_larger_reg;
    logic               equal_reg;
    logic               err_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   and_y;
    logic [WIDTH-1:0]   or_y;
    logic [WIDTH-1:0]   xor_y;
    logic [WIDTH-1:0]   not_y;
    logic [WIDTH-1:0]   cmp_c;
    logic               cmp_gt;
    logic               cmp_eq;

    logic [WIDTH-1:0]   exec_lo;
    logic               exec_carry;
    logic               exec_gt;
    logic               exec_eq;
    logic               exec_err;

    logic               accept;
    logic               mul_load;
    logic               mul_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product_next;

    full_adder #(.WIDTH(WIDTH)) u_add (
        .a(a_reg), .b(b_reg), .cin(1'b0), .sum(add_sum), .cout(add_cout)
    );
    ander  #(.WIDTH(WIDTH)) u_and (.a(a_reg), .b(b_reg), .y(and_y));
    orer   #(.WIDTH(WIDTH)) u_or  (.a(a_reg), .b(b_reg), .y(or_y));
    xorer  #(.WIDTH(WIDTH)) u_xor (.a(a_reg), .b(b_reg), .y(xor_y));
    notter #(.WIDTH(WIDTH)) u_not (.a(a_reg), .y(not_y));
    comparator #(.WIDTH(WIDTH)) u_cmp (
        .a(a_reg), .b(b_reg), .c(cmp_c), .a_larger(cmp_gt), .equal(cmp_eq)
    );

    // The multiplier latches its own operands on the same edge the FSM accepts start
    shift_add_mul_core #(.WIDTH(WIDTH)) u_mul (
        .clk         (clk),
        .rst_b       (rst_b),
        .load        (mul_load),
        .step        (mul_step),
        .multiplicand(a),
        .multiplier  (b),
        .last        (mul_last),
        .product_next(mul_product_next)
    );

    assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign mul_load = accept && is_mul(op);
    assign mul_step = (state_reg == S_MUL);

    always_comb begin
        exec_lo    = '0;
        exec_carry = 1'b0;
        exec_gt    = 1'b0;
        exec_eq    = 1'b0;
        exec_err   = 1'b0;
        case (op_reg)
            OP_ADD: begin
                exec_lo    = add_sum;
                exec_carry = add_cout;
            end
            OP_AND: exec_lo = and_y;
            OP_OR:  exec_lo = or_y;
            OP_XOR: exec_lo = xor_y;
            OP_NOT: exec_lo = not_y;
            OP_CMP: begin
                exec_lo = cmp_c;
                exec_gt = cmp_gt;
                exec_eq = cmp_eq;
            end
            OP_RSV: exec_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= S_IDLE;
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            a_larger_reg <= 1'b0;
            equal_reg    <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= is_mul(op) ? S_MUL : S_EXEC;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    result_reg   <= {{WIDTH{1'b0}}, exec_lo};
                    carry_reg    <= exec_carry;
                    zero_reg     <= (exec_lo == '0);
                    a_larger_reg <= exec_gt;
                    equal_reg    <= exec_eq;
                    err_reg      <= exec_err;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                    state_reg    <= S_DONE;
                end
                S_MUL: begin
                    // The final iteration's value is captured directly, saving a cycle
                    if (mul_last) begin
                        result_reg   <= mul_product_next;
                        carry_reg    <= 1'b0;
                        zero_reg     <= (mul_product_next == '0);
                        a_larger_reg <= 1'b0;
                        equal_reg    <= 1'b0;
                        err_reg      <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign carry    = carry_reg;
    assign zero     = zero_reg;
    assign a_larger = a_larger_reg;
    assign equal    = equal_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, handshake corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W       = 8;
    localparam int TIMEOUT = 40;

    logic           clk;
    logic           rst_b;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;
    logic           a_larger;
    logic           equal;
    logic           err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_result;
        logic           exp_carry;
        logic           exp_zero;
        logic           exp_gt;
        logic           exp_eq;
        logic           exp_err;
    } vec_t;

    vec_t vecs[14];

    alu_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .a_larger(a_larger),
        .equal   (equal),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the opcode's definition
    function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t v;
        int   s;
        v.op = o; v.a = x; v.b = y;
        v.exp_result = '0; v.exp_carry = 1'b0; v.exp_gt = 1'b0; v.exp_eq = 1'b0; v.exp_err = 1'b0;
        case (o)
            OP_ADD: begin
                s = int'(x) + int'(y);
                v.exp_result = 16'(s % 256);
                v.exp_carry  = (s > 255);
            end
            OP_AND: v.exp_result = {8'h00, x & y};
            OP_OR:  v.exp_result = {8'h00, x | y};
            OP_XOR: v.exp_result = {8'h00, x ^ y};
            OP_NOT: v.exp_result = {8'h00, ~x};
            OP_CMP: begin
                v.exp_result = {8'h00, x ^ y};
                v.exp_gt     = (x > y);
                v.exp_eq     = (x == y);
            end
            OP_MUL: begin
                s = int'(x) * int'(y);
                v.exp_result = 16'(s);
            end
            default: v.exp_err = 1'b1;
        endcase
        v.exp_zero = (v.exp_result == 16'h0000);
        return v;
    endfunction

    // Called just after a rising edge; returns once done is seen (or the bound expires)
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cycles);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int lat, bc, exp_lat;
        run_op(v.op, v.a, v.b, lat, bc);
        exp_lat = (v.op == OP_MUL) ? W : 1;
        $display("%s op=%0d a=%02h b=%02h -> result=%04h c=%0b z=%0b gt=%0b eq=%0b err=%0b lat=%0d",
                 tag, v.op, v.a, v.b, result, carry, zero, a_larger, equal, err, lat);
        chk($sformatf("%s.latency", tag), lat, exp_lat);
        chk($sformatf("%s.busy_cycles", tag), bc, exp_lat);
        chk($sformatf("%s.result", tag), result, v.exp_result);
        chk($sformatf("%s.carry", tag), carry, v.exp_carry);
        chk($sformatf("%s.zero", tag), zero, v.exp_zero);
        chk($sformatf("%s.a_larger", tag), a_larger, v.exp_gt);
        chk($sformatf("%s.equal", tag), equal, v.exp_eq);
        chk($sformatf("%s.err", tag), err, v.exp_err);
    endtask

    initial begin
        int lat, bc;
        logic [2:0] ro;
        logic [W-1:0] rx, ry;

        rst_b = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #3;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.result", result, 0);
        chk("reset.flags", {carry, zero, a_larger, equal, err}, 0);
        #19 rst_b = 1'b1;
        @(posedge clk); #1;

        vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_CMP, 8'h5A, 8'h5A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_CMP, 8'h80, 8'h7F, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_MUL, 8'h00, 8'h37, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_AND, 8'hCC, 8'hAA, 16'h0088, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_RSV, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_OR,  8'h0F, 8'hF0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_XOR, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_NOT, 8'h0F, 8'h55, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_CMP, 8'h7F, 8'h80, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: new start issued in the DONE cycle of the previous op
        apply_vec("b2b.first", model(OP_ADD, 8'h03, 8'h04));
        start = 1'b1; op = OP_AND; a = 8'hCC; b = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy", busy, 1);
        chk("b2b.done_early", done, 0);
        @(posedge clk); #1;
        $display("b2b.second AND cc aa -> done=%0b result=%04h", done, result);
        chk("b2b.done", done, 1);
        chk("b2b.result", result, 16'h0088);
        @(posedge clk); #1;
        chk("hold.done_pulse", done, 0);
        chk("hold.busy", busy, 0);
        chk("hold.result", result, 16'h0088);

        // start held high and operands changed while a multiply is busy
        start = 1'b1; op = OP_MUL; a = 8'h12; b = 8'h34;
        @(posedge clk); #1;
        op = OP_ADD; a = 8'h01; b = 8'h01;
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (lat == 3) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        $display("ignore.mul 12*34 -> result=%04h lat=%0d", result, lat);
        chk("ignore.latency", lat, W);
        chk("ignore.result", result, 16'h03A8);
        chk("ignore.carry", carry, 0);
        @(posedge clk); #1;
        chk("ignore.idle_busy", busy, 0);
        chk("ignore.idle_done", done, 0);

        // Asynchronous reset during multiply iteration 4
        start = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmul.busy_before", busy, 1);
        #2 rst_b = 1'b0;
        #1;
        $display("rstmul async reset -> busy=%0b done=%0b result=%04h err=%0b", busy, done, result, err);
        chk("rstmul.busy", busy, 0);
        chk("rstmul.done", done, 0);
        chk("rstmul.result", result, 0);
        chk("rstmul.flags", {carry, zero, a_larger, equal, err}, 0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;
        chk("rstmul.idle_busy", busy, 0);
        chk("rstmul.idle_done", done, 0);
        apply_vec("rstmul.add", '{OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Reserved op sets err; the next accepted start clears it immediately
        apply_vec("rsv", '{OP_RSV, 8'hAB, 8'hCD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        start = 1'b1; op = OP_ADD; a = 8'h05; b = 8'h06;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rsv.err_cleared", err, 0);
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("rsv.next ADD 05 06 -> result=%04h err=%0b", result, err);
        chk("rsv.next_result", result, 16'h000B);
        chk("rsv.next_err", err, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            apply_vec($sformatf("rnd%0d", i), model(ro, rx, ry));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
